// File: rtl/regfile_mp_pkg.sv
// Shared state encoding and default parameters for the multi-read-port register file.
package regfile_mp_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_DEF   = 2;
    localparam bit ZERO_REG_DEF = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: array mux, write-first bypass, zero-register and clear overrides.
module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  mem,
    input  logic [ADDR_W-1:0]                   rd_addr,
    input  logic                                wr_acc,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    input  logic                                clearing,
    output logic [DATA_W-1:0]                   rd_data
);

    logic [DATA_W-1:0] rd_data_d, rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
        // Zero override sits ahead of the bypass so a dropped r0 write never leaks out.
        if (clearing || (ZERO_REG && rd_addr == '0)) begin
            rd_data_d = '0;
        end else if (wr_acc && wr_addr == rd_addr) begin
            rd_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, one write port, bulk-clear engine.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e                        state_q, state_d;
    logic [ADDR_W-1:0]             ptr_q, ptr_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic                          wr_acc;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mem_d    = mem_q;
        wr_ready = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        wr_acc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready = 1'b1;
                wr_acc   = wr_en;
                // r0 writes still handshake as accepted but never land.
                if (wr_acc && !(ZERO_REG && wr_addr == '0)) mem_d[wr_addr] = wr_data;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                clr_busy     = 1'b1;
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) begin
                    clr_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk      (clk),
            .reset    (reset),
            .mem      (mem_q),
            .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
            .wr_acc   (wr_acc),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .clearing (clr_busy),
            .rd_data  (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule
